ifetch_ctrl: RTL and testbench
==============================

# ifetch_ctrl

Instruction-fetch controller that consumes the next-PC selection (flush > redirect > PC+4) and turns it into fetch traffic. It owns the architectural fetch PC register and issues single-outstanding requests on the instruction bus. It discards responses made stale by a redirect or flush and presents each fetched instruction to decode over a valid/ready handshake. It sits between the next-PC mux and the decode stage, driving the instruction-memory port.

## Interface
- RESET_PC, 64'h8000_0000, fetch PC loaded on reset
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- redirect_valid  in  1  branch/jump redirect from execute
- redirect_target  in  64  redirect PC
- flush  in  1  CSR/trap flush; overrides redirect
- csr_new_pc_i  in  64  flush target PC
- ireq_valid  out  1  fetch request valid
- ireq_addr  out  64  fetch address (current PC)
- ireq_ready  in  1  bus accepts request
- iresp_valid  in  1  response valid, one per accepted request, ≥1 cycle after acceptance
- iresp_data  in  32  instruction word
- out_valid  out  1  instruction valid to decode
- out_pc  out  64  PC of out_instr
- out_instr  out  32  fetched instruction
- out_ready  in  1  decode accepts
- pc_o  out  64  current fetch PC register

## Operation
- States: REQ, WAIT, HOLD, DRAIN. Registers: pc, state, instr.
- "Kill" means flush or redirect_valid. New pc on kill is flush ? csr_new_pc_i : redirect_target.
- REQ: ireq_valid=1, ireq_addr=pc.
  - ireq_ready & !kill -> WAIT.
  - ireq_ready & kill -> pc=target, DRAIN. The accepted request is stale.
  - !ireq_ready & kill -> pc=target, stay REQ. The address may change while unaccepted.
- WAIT: ireq_valid=0.
  - iresp_valid & !kill -> instr=iresp_data, HOLD.
  - iresp_valid & kill -> discard, pc=target, REQ.
  - !iresp_valid & kill -> pc=target, DRAIN.
- HOLD: out_valid=1, out_pc=pc, out_instr=instr.
  - out_ready & !kill -> pc=pc+4, REQ.
  - kill (regardless of out_ready) -> pc=target, REQ. A same-cycle out handshake still counts as a transfer. pc takes the target, not pc+4.
- DRAIN: ireq_valid=0, out_valid=0.
  - iresp_valid -> discard, REQ. The pc is the latest target: any same-cycle kill updates it.
  - !iresp_valid & kill -> pc=target, stay DRAIN.
- Width rules:
  - pc+4 is 64-bit modulo. 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
  - No alignment check; low bits pass through.
- A response arriving in REQ or HOLD is a protocol violation. Assert it in simulation and ignore it in RTL.

## Timing
- Reset (async assert, sync release):
  - state=REQ, pc=RESET_PC, instr=0.
  - ireq_valid=0 while rst_n=0.
  - out_valid=0, out_pc=RESET_PC, out_instr=0.
  - First request is in the cycle after release.
- Outputs are decoded from registered state only. There is no combinational path from kill, ireq_ready or out_ready to any output.
- Best-case pipeline, request accepted at cycle t:
  - response at t+1;
  - out_valid at t+2; consumed at t+2 if out_ready;
  - next request at t+3.
- Peak throughput is 1 instruction per 3 cycles.
- Kill latency: from the cycle after a kill, pc_o and ireq_addr reflect the target, and out_valid is 0 or refers only to the new stream.
- rst_n asserted mid-operation aborts everything immediately. Any response arriving after release is the bus's responsibility; the bus is reset together with this block.

## Structure
- Shared package ifu_pkg: fetch_state_t enum (REQ, WAIT, HOLD, DRAIN), addr_t (logic[63:0]), inst_t (logic[31:0]), default RESET_PC constant.
- One sub-module: the existing pcnxt instance computes the next pc from pc, redirect and flush. Its sequential +4 input is gated so it advances only on an out handshake.
- Simulation-only assertions:
  - single outstanding request;
  - no response outside WAIT/DRAIN;
  - ireq_valid deasserts only via acceptance or kill.

## Test plan
- Reset then ireq_ready=1, response 1 cycle later with 32'h0000_0013, out_ready=1 -> ireq_addr=8000_0000; out_pc=8000_0000, out_instr=0000_0013 at t+2; next ireq_addr=8000_0004 at t+3.
- Redirect to 8000_0100 in WAIT before the response -> the old response is discarded (no out_valid); the next request is to 8000_0100.
- flush with csr_new_pc_i=8000_0200 together with redirect_valid to 8000_0100 in HOLD, out_ready=0 -> held instruction dropped; next request is to 8000_0200.
- ireq_ready held 0 for 5 cycles, redirect in cycle 3 -> ireq_valid stays 1; ireq_addr switches to the target in cycle 4; exactly one request is accepted.
- out_ready=0 for 10 cycles in HOLD -> out_valid, out_pc and out_instr stay stable; no new ireq_valid.
- pc=FFFF_FFFF_FFFF_FFFC consumed -> next ireq_addr=0. Async reset mid-WAIT -> all outputs take their reset values immediately.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch unit.
package ifu_pkg;

    typedef logic [63:0] addr_t;
    typedef logic [31:0] inst_t;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    localparam addr_t DEFAULT_RESET_PC = 64'h8000_0000;

    // Sequential fetch step; wraps modulo 2^64 and leaves the low bits alone.
    function automatic addr_t pc_plus4(input addr_t pc);
        return pc + 64'd4;
    endfunction

endpackage

// File: rtl/ifetch_ctrl_if.sv
// Instruction-bus request/response and decode-side handshake bundle.
interface ifetch_ctrl_if;
    import ifu_pkg::*;

    logic  ireq_valid;
    addr_t ireq_addr;
    logic  ireq_ready;
    logic  iresp_valid;
    inst_t iresp_data;
    logic  out_valid;
    addr_t out_pc;
    inst_t out_instr;
    logic  out_ready;

    modport master (
        output ireq_valid, ireq_addr, out_valid, out_pc, out_instr,
        input  ireq_ready, iresp_valid, iresp_data, out_ready
    );

    modport slave (
        input  ireq_valid, ireq_addr, out_valid, out_pc, out_instr,
        output ireq_ready, iresp_valid, iresp_data, out_ready
    );

endinterface

// File: rtl/ifetch_ctrl_pcnxt.sv
// Next-PC selection: flush target over redirect target over pc+4 over hold.
module ifetch_ctrl_pcnxt
    import ifu_pkg::*;
(
    input  addr_t pc_i,
    input  logic  inc_en_i,
    input  logic  redirect_valid_i,
    input  addr_t redirect_target_i,
    input  logic  flush_i,
    input  addr_t csr_new_pc_i,
    output addr_t pc_nxt_o,
    output logic  kill_o
);

    always_comb begin
        pc_nxt_o = pc_i;
        kill_o   = flush_i | redirect_valid_i;
        if (flush_i) begin
            pc_nxt_o = csr_new_pc_i;
        end else if (redirect_valid_i) begin
            pc_nxt_o = redirect_target_i;
        end else if (inc_en_i) begin
            pc_nxt_o = pc_plus4(pc_i);
        end
    end

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch controller: owns the fetch PC, issues one outstanding request at a time,
// drops responses made stale by a kill and hands instructions to decode.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   REQ   | request for pc presented on the bus, waiting for acceptance
//   WAIT  | request accepted, response still owed for the current pc
//   HOLD  | fetched instruction offered to decode
//   DRAIN | accepted request is stale, swallowing its response
module ifetch_ctrl
    import ifu_pkg::*;
#(
    parameter addr_t RESET_PC = DEFAULT_RESET_PC
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          redirect_valid,
    input  addr_t         redirect_target,
    input  logic          flush,
    input  addr_t         csr_new_pc_i,
    ifetch_ctrl_if.master bus,
    output addr_t         pc_o
);

    fetch_state_t state_q, state_d;
    addr_t        pc_q, pc_d;
    inst_t        instr_q, instr_d;
    logic         run_q, run_d;
    logic         kill;
    logic         adv;

    // run_q keeps ireq_valid low while in reset and for the release cycle.
    assign run_d = 1'b1;

    ifetch_ctrl_pcnxt u_pcnxt (
        .pc_i              (pc_q),
        .inc_en_i          (adv),
        .redirect_valid_i  (redirect_valid & run_q),
        .redirect_target_i (redirect_target),
        .flush_i           (flush & run_q),
        .csr_new_pc_i      (csr_new_pc_i),
        .pc_nxt_o          (pc_d),
        .kill_o            (kill)
    );

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        adv     = 1'b0;
        if (run_q) begin
            case (state_q)
                REQ: begin
                    if (bus.ireq_ready) begin
                        state_d = kill ? DRAIN : WAIT;
                    end
                end
                WAIT: begin
                    if (bus.iresp_valid) begin
                        if (kill) begin
                            state_d = REQ;
                        end else begin
                            instr_d = bus.iresp_data;
                            state_d = HOLD;
                        end
                    end else if (kill) begin
                        state_d = DRAIN;
                    end
                end
                HOLD: begin
                    if (kill) begin
                        state_d = REQ;
                    end else if (bus.out_ready) begin
                        adv     = 1'b1;
                        state_d = REQ;
                    end
                end
                DRAIN: begin
                    if (bus.iresp_valid) begin
                        state_d = REQ;
                    end
                end
                default: state_d = REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            run_q   <= run_d;
        end
    end

    assign bus.ireq_valid = run_q & (state_q == REQ);
    assign bus.ireq_addr  = pc_q;
    assign bus.out_valid  = (state_q == HOLD);
    assign bus.out_pc     = pc_q;
    assign bus.out_instr  = instr_q;
    assign pc_o           = pc_q;

`ifndef SYNTHESIS
    logic outst_q;
    logic req_pend_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outst_q    <= 1'b0;
            req_pend_q <= 1'b0;
        end else begin
            if (bus.ireq_valid && bus.ireq_ready) begin
                outst_q <= 1'b1;
            end else if (bus.iresp_valid) begin
                outst_q <= 1'b0;
            end
            req_pend_q <= bus.ireq_valid & ~bus.ireq_ready;
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(bus.ireq_valid && bus.ireq_ready && outst_q))
                else $error("second request accepted while one is outstanding");
            assert (!(bus.iresp_valid && (state_q == REQ || state_q == HOLD)))
                else $error("instruction response outside WAIT/DRAIN");
            assert (!req_pend_q || bus.ireq_valid)
                else $error("ireq_valid dropped without acceptance");
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a flag-based behavioural model.
module tb_ifetch_ctrl;
    import ifu_pkg::*;

    logic  clk = 1'b0;
    logic  rst_n = 1'b1;
    logic  rv, fl, rdy, ordy, resp_v;
    addr_t rt, cp, pc_o;
    inst_t resp_d;
    int    checks = 0;
    int    failures = 0;
    int    lat_lo = 0, lat_hi = 0;
    int    acc;

    always #5 clk = ~clk;

    ifetch_ctrl_if ifc ();
    assign ifc.ireq_ready  = rdy;
    assign ifc.out_ready   = ordy;
    assign ifc.iresp_valid = resp_v;
    assign ifc.iresp_data  = resp_d;

    ifetch_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_valid  (rv),
        .redirect_target (rt),
        .flush           (fl),
        .csr_new_pc_i    (cp),
        .bus             (ifc),
        .pc_o            (pc_o)
    );

    // Instruction memory contents seen by the bench's bus.
    function automatic inst_t mem(input addr_t a);
        if (a == 64'h8000_0000) return 32'h0000_0013;
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_0013;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Model: run = past first cycle after reset; pend = a request is owed a response;
    // stale = that response must be dropped; have = an instruction sits with decode.
    logic  m_run, m_pend, m_stale, m_have;
    addr_t m_pc;
    inst_t m_instr;
    logic  bus_pend;
    int    bus_cnt;
    addr_t bus_addr;

    always @(posedge clk or negedge rst_n) begin : model
        logic  kill, pend, stale, have, accept;
        addr_t pc, tgt;
        inst_t ins;
        if (!rst_n) begin
            m_run    <= 1'b0;
            m_pc     <= 64'h8000_0000;
            m_pend   <= 1'b0;
            m_stale  <= 1'b0;
            m_have   <= 1'b0;
            m_instr  <= '0;
            bus_pend <= 1'b0;
            bus_cnt  <= 0;
            bus_addr <= '0;
        end else begin
            kill   = fl | rv;
            tgt    = fl ? cp : rt;
            pc     = m_pc;
            pend   = m_pend;
            stale  = m_stale;
            have   = m_have;
            ins    = m_instr;
            accept = 1'b0;
            if (m_run) begin
                if (have) begin
                    if (kill) begin
                        pc = tgt;
                        have = 1'b0;
                    end else if (ordy) begin
                        pc = pc + 64'd4;
                        have = 1'b0;
                    end
                end else if (!pend) begin
                    if (rdy) begin
                        pend = 1'b1;
                        stale = kill;
                        accept = 1'b1;
                    end
                    if (kill) pc = tgt;
                end else begin
                    if (resp_v) begin
                        pend = 1'b0;
                        if (!stale && !kill) begin
                            have = 1'b1;
                            ins = resp_d;
                        end
                    end else if (kill) begin
                        stale = 1'b1;
                    end
                    if (kill) pc = tgt;
                end
            end
            m_run   <= 1'b1;
            m_pc    <= pc;
            m_pend  <= pend;
            m_stale <= stale;
            m_have  <= have;
            m_instr <= ins;
            if (accept) begin
                bus_pend <= 1'b1;
                bus_addr <= m_pc;
                bus_cnt  <= int'($urandom_range(lat_hi, lat_lo));
            end else if (resp_v) begin
                bus_pend <= 1'b0;
            end else if (bus_pend && bus_cnt > 0) begin
                bus_cnt <= bus_cnt - 1;
            end
        end
    end

    always @(negedge clk) begin
        check("ireq_valid", {63'd0, ifc.ireq_valid}, {63'd0, m_run & ~m_pend & ~m_have});
        check("ireq_addr", ifc.ireq_addr, m_pc);
        check("out_valid", {63'd0, ifc.out_valid}, {63'd0, m_have});
        check("out_pc", ifc.out_pc, m_pc);
        check("out_instr", {32'd0, ifc.out_instr}, {32'd0, m_instr});
        check("pc_o", pc_o, m_pc);
    end

    task automatic tick();
        @(negedge clk);
        #1;
        resp_v = bus_pend && (bus_cnt == 0);
        resp_d = mem(bus_addr);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ireq_valid"}, {63'd0, ifc.ireq_valid}, 64'd0);
        check({tag, "_out_valid"}, {63'd0, ifc.out_valid}, 64'd0);
        check({tag, "_out_pc"}, ifc.out_pc, 64'h8000_0000);
        check({tag, "_out_instr"}, {32'd0, ifc.out_instr}, 64'd0);
        check({tag, "_pc_o"}, pc_o, 64'h8000_0000);
    endtask

    initial begin
        rv = 0; fl = 0; rt = '0; cp = '0; rdy = 0; ordy = 0; resp_v = 0; resp_d = '0;
        #1 rst_n = 1'b0;
        #11;
        check_reset_outputs("rst");
        tick();
        rst_n = 1'b1;

        // basic fetch, best-case latency
        tick();
        check("first_req_valid", {63'd0, ifc.ireq_valid}, 64'd1);
        check("first_req_addr", ifc.ireq_addr, 64'h8000_0000);
        rdy = 1; ordy = 1;
        tick();
        rdy = 0;
        check("t1_no_req", {63'd0, ifc.ireq_valid}, 64'd0);
        tick();
        check("t2_out_valid", {63'd0, ifc.out_valid}, 64'd1);
        check("t2_out_pc", ifc.out_pc, 64'h8000_0000);
        check("t2_out_instr", {32'd0, ifc.out_instr}, 64'h13);
        tick();
        check("t3_req_valid", {63'd0, ifc.ireq_valid}, 64'd1);
        check("t3_req_addr", ifc.ireq_addr, 64'h8000_0004);

        // redirect while waiting: old response discarded
        lat_lo = 2; lat_hi = 2; rdy = 1;
        tick();
        rdy = 0; rv = 1; rt = 64'h8000_0100;
        tick();
        rv = 0;
        check("drain_no_req", {63'd0, ifc.ireq_valid}, 64'd0);
        check("drain_pc", pc_o, 64'h8000_0100);
        tick();
        check("drain_resp_no_out", {63'd0, ifc.out_valid}, 64'd0);
        tick();
        check("redir_req_valid", {63'd0, ifc.ireq_valid}, 64'd1);
        check("redir_req_addr", ifc.ireq_addr, 64'h8000_0100);

        // flush beats redirect while holding
        lat_lo = 0; lat_hi = 0; rdy = 1; ordy = 0;
        tick();
        rdy = 0;
        tick();
        check("hold_valid", {63'd0, ifc.out_valid}, 64'd1);
        check("hold_instr", {32'd0, ifc.out_instr}, {32'd0, mem(64'h8000_0100)});
        fl = 1; cp = 64'h8000_0200; rv = 1; rt = 64'h8000_0100;
        tick();
        fl = 0; rv = 0;
        check("flush_drop", {63'd0, ifc.out_valid}, 64'd0);
        check("flush_req_addr", ifc.ireq_addr, 64'h8000_0200);

        // unaccepted request retargeted by a redirect
        for (int i = 1; i <= 5; i++) begin
            check("stall_req_valid", {63'd0, ifc.ireq_valid}, 64'd1);
            if (i >= 4) check("stall_addr_new", ifc.ireq_addr, 64'h8000_0300);
            else        check("stall_addr_old", ifc.ireq_addr, 64'h8000_0200);
            rv = (i == 3);
            rt = 64'h8000_0300;
            tick();
        end
        rv = 0; rdy = 1; acc = 0;
        for (int j = 0; j < 4; j++) begin
            if (ifc.ireq_valid && rdy) acc++;
            tick();
            rdy = 0;
        end
        check("one_accept", 64'(acc), 64'd1);

        // decode back-pressure
        for (int k = 0; k < 10; k++) begin
            check("bp_out_valid", {63'd0, ifc.out_valid}, 64'd1);
            check("bp_out_pc", ifc.out_pc, 64'h8000_0300);
            check("bp_out_instr", {32'd0, ifc.out_instr}, {32'd0, mem(64'h8000_0300)});
            check("bp_no_req", {63'd0, ifc.ireq_valid}, 64'd0);
            tick();
        end
        ordy = 1;
        tick();
        check("bp_next_addr", ifc.ireq_addr, 64'h8000_0304);

        // pc wrap
        rv = 1; rt = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        rv = 0;
        check("wrap_req_addr", ifc.ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        rdy = 1;
        tick();
        rdy = 0;
        tick();
        check("wrap_out_pc", ifc.out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        check("wrap_next_addr", ifc.ireq_addr, 64'h0);

        // async reset in WAIT
        lat_lo = 2; lat_hi = 2; rdy = 1;
        tick();
        rdy = 0;
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async");
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_req", {63'd0, ifc.ireq_valid}, 64'd1);
        check("post_rst_addr", ifc.ireq_addr, 64'h8000_0000);

        // randomized traffic
        lat_lo = 0; lat_hi = 3;
        for (int n = 0; n < 4000; n++) begin
            rdy  = ($urandom_range(0, 2) != 0);
            ordy = ($urandom_range(0, 4) > 1);
            rv   = ($urandom_range(0, 9) == 0);
            fl   = ($urandom_range(0, 24) == 0);
            rt   = {32'h0, $urandom};
            cp   = {$urandom, $urandom};
            tick();
        end
        rv = 0; fl = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
